// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [4:0] PRESCALE_8     = 5'd8;
  localparam logic [4:0] PRESCALE_16    = 5'd16;
  localparam int         DATA_WIDTH_DEF = 8;

  // Anything other than 16 runs the frame at 8x oversampling.
  function automatic logic [4:0] norm_prescale(input logic [4:0] p);
    return (p == PRESCALE_16) ? PRESCALE_16 : PRESCALE_8;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX frame controller and its neighbours
// (serial line, sampler, byte consumer).
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH_DEF
);
  logic                  rx_in;
  logic [4:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  sampled_bit;
  logic                  data_samp_en;
  logic [4:0]            edge_cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  strt_glitch;

  // Controller side.
  modport slave (
    input  rx_in, prescale, par_en, par_typ, sampled_bit,
    output data_samp_en, edge_cnt, bit_cnt, p_data,
           data_valid, par_err, stp_err, strt_glitch
  );

  // Environment side (line driver, sampler, consumer).
  modport master (
    output rx_in, prescale, par_en, par_typ, sampled_bit,
    input  data_samp_en, edge_cnt, bit_cnt, p_data,
           data_valid, par_err, stp_err, strt_glitch
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter. Both sit at zero
// whenever the enable is low, so a new frame always starts from 0/0.
module uart_rx_edge_bit_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [4:0] i_pre,
  output logic [4:0] o_edge_cnt,
  output logic [3:0] o_bit_cnt,
  output logic       o_bit_done
);
  logic [4:0] r_edge;
  logic [3:0] r_bit;

  // Last oversampling edge of the current bit; the sampler result is ready here.
  assign o_bit_done = (r_edge == i_pre - 5'd1);
  assign o_edge_cnt = r_edge;
  assign o_bit_cnt  = r_bit;

  // Count edges 0..P-1, wrap, and advance the bit index on each wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (!i_en) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (o_bit_done) begin
      r_edge <= '0;
      r_bit  <= r_bit + 4'd1;
    end else begin
      r_edge <= r_edge + 5'd1;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit timing for the
// majority-vote sampler, LSB-first deserialization, parity/stop checks.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_ctrl_if.slave bus
);
  rx_state_e             r_state, w_next;
  logic [4:0]            r_pre;
  logic                  r_par_en, r_par_typ;
  logic [DATA_WIDTH-1:0] r_shift, r_p_data;
  logic                  r_par, r_par_fail;
  logic                  r_samp_en, r_dv, r_par_err, r_stp_err, r_glitch;

  logic                  w_start, w_shift_en, w_par_chk, w_load;
  logic                  w_samp_en, w_dv, w_par_err, w_stp_err, w_glitch;
  logic                  w_cnt_en, w_bit_done;
  logic [4:0]            w_edge_cnt;
  logic [3:0]            w_bit_cnt;

  // Counters run only while the frame continues; the edge that ends a
  // frame also clears them so IDLE always shows 0/0.
  assign w_cnt_en = (r_state != ST_IDLE) && (w_next != ST_IDLE);

  uart_rx_edge_bit_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_cnt_en),
    .i_pre      (r_pre),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_bit_done (w_bit_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state and next values of the registered strobes.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    w_par_chk  = 1'b0;
    w_load     = 1'b0;
    w_dv       = 1'b0;
    w_par_err  = 1'b0;
    w_stp_err  = 1'b0;
    w_glitch   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.rx_in) begin
          w_next  = ST_START;
          w_start = 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          if (bus.sampled_bit) begin
            w_next   = ST_IDLE;
            w_glitch = 1'b1;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_shift_en = 1'b1;
          if (w_bit_cnt == 4'(DATA_WIDTH))
            w_next = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_done) begin
          w_par_chk = 1'b1;
          w_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_done) begin
          w_next    = ST_IDLE;
          w_stp_err = !bus.sampled_bit;
          w_par_err = r_par_fail;
          w_dv      = bus.sampled_bit && !r_par_fail;
          w_load    = w_dv;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // Sampler must stay enabled for the whole frame or it drops its votes.
    w_samp_en = (w_next != ST_IDLE);
  end

  // Frame configuration, deserializer, parity tracking and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre      <= PRESCALE_8;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_fail <= 1'b0;
      r_p_data   <= '0;
      r_samp_en  <= 1'b0;
      r_dv       <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
      r_glitch   <= 1'b0;
    end else begin
      r_samp_en <= w_samp_en;
      r_dv      <= w_dv;
      r_par_err <= w_par_err;
      r_stp_err <= w_stp_err;
      r_glitch  <= w_glitch;
      if (w_start) begin
        r_pre      <= norm_prescale(bus.prescale);
        r_par_en   <= bus.par_en;
        r_par_typ  <= bus.par_typ;
        r_shift    <= '0;
        r_par      <= 1'b0;
        r_par_fail <= 1'b0;
      end
      if (w_shift_en) begin
        r_shift <= {bus.sampled_bit, r_shift[DATA_WIDTH-1:1]};
        r_par   <= r_par ^ bus.sampled_bit;
      end
      if (w_par_chk)
        r_par_fail <= (bus.sampled_bit != (r_par ^ r_par_typ));
      if (w_load)
        r_p_data <= r_shift;
    end
  end

  assign bus.data_samp_en = r_samp_en;
  assign bus.edge_cnt     = w_edge_cnt;
  assign bus.bit_cnt      = w_bit_cnt;
  assign bus.p_data       = r_p_data;
  assign bus.data_valid   = r_dv;
  assign bus.par_err      = r_par_err;
  assign bus.stp_err      = r_stp_err;
  assign bus.strt_glitch  = r_glitch;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table of directed frames, randomized frames
// against a frame-level model, and hand sequences for glitch, reset and
// back-to-back corner cases. The sampler is modelled as ideal (it reports
// the bit currently on the line).
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_pdata = 8'h00;

  uart_rx_ctrl_if #(.DATA_WIDTH(8)) ifc ();
  assign ifc.sampled_bit = ifc.rx_in;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: stamp = number of the edge after which the pulse is visible.
  int         dv_q[$];
  logic [7:0] dvd_q[$];
  int         pe_q[$];
  int         se_q[$];
  int         gl_q[$];
  always @(negedge clk) begin
    if (ifc.data_valid)  begin dv_q.push_back(cyc); dvd_q.push_back(ifc.p_data); end
    if (ifc.par_err)     pe_q.push_back(cyc);
    if (ifc.stp_err)     se_q.push_back(cyc);
    if (ifc.strt_glitch) gl_q.push_back(cyc);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] pre;
    bit         pe;
    bit         pt;
    logic [7:0] d;
    bit         pbit;
    bit         stop;
    bit         edv;
    bit         epe;
    bit         ese;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int find_at(input int q[$], input int t);
    foreach (q[i]) if (q[i] == t) return i;
    return -1;
  endfunction

  // Starts at #1 after an edge; the next edge is the frame's edge 0.
  // Returns #1 after the final decision edge with the stop level still driven.
  task automatic send_frame(input logic [4:0] pre, input bit pe, input bit pt,
                            input logic [7:0] d, input bit pbit, input bit stop,
                            output int c0);
    int P, n;
    logic [10:0] bits;
    P = (pre == 5'd16) ? 16 : 8;
    n = pe ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe) begin bits[9] = pbit; bits[10] = stop; end
    else    bits[9] = stop;
    ifc.prescale = pre;
    ifc.par_en   = pe;
    ifc.par_typ  = pt;
    c0 = cyc + 1;
    ifc.rx_in = 1'b0;
    for (int k = 1; k < n; k++) begin
      repeat ((k == 1) ? P + 1 : P) @(posedge clk);
      #1 ifc.rx_in = bits[k];
      if (k == 1) begin
        // Mid-frame config changes must not disturb this frame.
        ifc.prescale = 5'($urandom);
        ifc.par_en   = 1'($urandom);
        ifc.par_typ  = 1'($urandom);
      end
    end
    repeat (P) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int t, input logic [7:0] d,
                             input bit edv, input bit epe, input bit ese);
    int i;
    i = find_at(dv_q, t);
    chk({tag, "_dv"}, 32'(i >= 0), 32'(edv));
    if (i >= 0) chk({tag, "_pdata"}, 32'(dvd_q[i]), 32'(d));
    i = find_at(pe_q, t);
    chk({tag, "_par_err"}, 32'(i >= 0), 32'(epe));
    i = find_at(se_q, t);
    chk({tag, "_stp_err"}, 32'(i >= 0), 32'(ese));
  endtask

  // Every pulse seen since the last group must be accounted for.
  task automatic end_group(input string tag, input int exp_n);
    chk({tag, "_npulses"}, 32'(dv_q.size() + pe_q.size() + se_q.size() + gl_q.size()),
        32'(exp_n));
    dv_q.delete(); dvd_q.delete(); pe_q.delete(); se_q.delete(); gl_q.delete();
  endtask

  task automatic run_one(input string tag, input vec_t v);
    int c0, P, n;
    P = (v.pre == 5'd16) ? 16 : 8;
    n = v.pe ? 11 : 10;
    send_frame(v.pre, v.pe, v.pt, v.d, v.pbit, v.stop, c0);
    ifc.rx_in = 1'b1;
    repeat (2 + $urandom_range(0, 4)) @(posedge clk);
    #1;
    check_frame(tag, c0 + n * P, v.d, v.edv, v.epe, v.ese);
    if (v.edv) exp_pdata = v.d;
    chk({tag, "_pdata_hold"}, 32'(ifc.p_data), 32'(exp_pdata));
    end_group(tag, int'(v.edv) + int'(v.epe) + int'(v.ese));
  endtask

  vec_t vt[7];

  initial begin
    int c0, c1;
    vec_t v;
    bit good_par;

    vt[0] = '{5'd8,  0, 0, 8'hA5, 0, 1, 1, 0, 0};
    vt[1] = '{5'd16, 1, 0, 8'h3C, 1, 1, 0, 1, 0};
    vt[2] = '{5'd8,  1, 1, 8'h00, 1, 0, 0, 0, 1};
    vt[3] = '{5'd16, 0, 0, 8'hFF, 0, 1, 1, 0, 0};
    vt[4] = '{5'd8,  1, 0, 8'h81, 1, 0, 0, 1, 1};
    vt[5] = '{5'd5,  1, 1, 8'h7E, 1, 1, 1, 0, 0};
    vt[6] = '{5'd16, 1, 1, 8'h01, 0, 1, 1, 0, 0};

    rst = 1'b0;
    ifc.rx_in = 1'b1;
    ifc.prescale = 5'd8;
    ifc.par_en = 1'b0;
    ifc.par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_samp_en", 32'(ifc.data_samp_en), 0);
    chk("rst_edge_cnt", 32'(ifc.edge_cnt), 0);
    chk("rst_bit_cnt", 32'(ifc.bit_cnt), 0);
    chk("rst_p_data", 32'(ifc.p_data), 0);
    chk("rst_pulses", 32'({ifc.data_valid, ifc.par_err, ifc.stp_err, ifc.strt_glitch}), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 7; i++) run_one($sformatf("vec%0d", i), vt[i]);

    // Start glitch: line low for two cycles only.
    ifc.prescale = 5'd8; ifc.par_en = 1'b0;
    c0 = cyc + 1;
    ifc.rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 ifc.rx_in = 1'b1;
    repeat (8 - 2) @(posedge clk);
    #1;
    chk("gl_samp_en_before", 32'(ifc.data_samp_en), 1);
    chk("gl_glitch_before", 32'(ifc.strt_glitch), 0);
    @(posedge clk); #1;
    chk("gl_glitch", 32'(ifc.strt_glitch), 1);
    chk("gl_samp_en_after", 32'(ifc.data_samp_en), 0);
    chk("gl_cnts_idle", 32'({ifc.edge_cnt, ifc.bit_cnt}), 0);
    @(posedge clk); #1;
    chk("gl_glitch_one_cycle", 32'(ifc.strt_glitch), 0);
    chk("gl_stamp", 32'(find_at(gl_q, c0 + 8) >= 0), 1);
    end_group("gl", 1);

    // Back-to-back frames, no idle between stop and the next start.
    send_frame(5'd8, 0, 0, 8'h55, 0, 1, c0);
    send_frame(5'd8, 0, 0, 8'hF0, 0, 1, c1);
    ifc.rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_frame("b2b0", c0 + 80, 8'h55, 1, 0, 0);
    check_frame("b2b1", c1 + 80, 8'hF0, 1, 0, 0);
    exp_pdata = 8'hF0;
    chk("b2b_pdata_hold", 32'(ifc.p_data), 32'(exp_pdata));
    end_group("b2b", 2);

    // Reset in the middle of a frame (line held low: start plus zero data).
    ifc.prescale = 5'd8; ifc.par_en = 1'b0;
    ifc.rx_in = 1'b0;
    repeat (41) @(posedge clk);
    #1;
    chk("mid_edge_cnt", 32'(ifc.edge_cnt), 0);
    chk("mid_bit_cnt", 32'(ifc.bit_cnt), 5);
    chk("mid_samp_en", 32'(ifc.data_samp_en), 1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_samp_en", 32'(ifc.data_samp_en), 0);
    chk("mrst_cnts", 32'({ifc.edge_cnt, ifc.bit_cnt}), 0);
    chk("mrst_p_data", 32'(ifc.p_data), 0);
    chk("mrst_pulses", 32'({ifc.data_valid, ifc.par_err, ifc.stp_err, ifc.strt_glitch}), 0);
    exp_pdata = 8'h00;
    ifc.rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    end_group("mrst", 0);
    v = '{5'd8, 0, 0, 8'hC3, 0, 1, 1, 0, 0};
    run_one("post_rst", v);

    // Randomized frames against the frame-level model.
    for (int r = 0; r < 40; r++) begin
      case ($urandom % 4)
        0:       v.pre = 5'd8;
        1, 2:    v.pre = 5'd16;
        default: v.pre = 5'($urandom);
      endcase
      v.pe   = 1'($urandom);
      v.pt   = 1'($urandom);
      v.d    = 8'($urandom);
      v.pbit = 1'($urandom);
      v.stop = ($urandom % 6) != 0;
      good_par = !v.pe || (v.pbit == ((^v.d) ^ v.pt));
      v.edv = v.stop && good_par;
      v.epe = !good_par;
      v.ese = !v.stop;
      run_one($sformatf("rnd%0d", r), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame controller for the UART receive path. It detects the start bit, runs the oversampling edge and bit counters that drive the majority-vote `data_sampling` block, and consumes its `sampled_bit`. It checks the start, parity and stop bits, deserializes the data byte LSB-first, and presents `p_data` with a one-cycle `data_valid` pulse to the consumer above the RX top level.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `clk` input, 1 bit: system clock, oversampling rate.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `rx_in` input, 1 bit: serial line, already synchronized; idle high.
- `prescale` input, 5 bits: oversampling ratio; legal values 8 and 16.
- `par_en` input, 1 bit: parity bit present.
- `par_typ` input, 1 bit: 0 = even, 1 = odd.
- `sampled_bit` input, 1 bit: majority-voted bit from `data_sampling`.
- `data_samp_en` output, 1 bit: enable to `data_sampling`.
- `edge_cnt` output, 5 bits: oversampling edge index within the current bit.
- `bit_cnt` output, 4 bits: bit index within the frame (0 = start).
- `p_data` output, DATA_WIDTH bits: received byte.
- `data_valid` output, 1 bit: one-cycle pulse, frame accepted.
- `par_err` output, 1 bit: one-cycle pulse, parity mismatch.
- `stp_err` output, 1 bit: one-cycle pulse, stop bit sampled 0.
- `strt_glitch` output, 1 bit: one-cycle pulse, start bit sampled 1.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE to START: on the clock edge where `rx_in`=0. Latch `prescale`, `par_en` and `par_typ`; `edge_cnt`=0, `bit_cnt`=0. A latched prescale other than 16 is treated as 8.
- Edge counter: in every non-IDLE state it counts 0..P-1 (P = latched prescale) and wraps to 0. `bit_cnt` increments on each wrap.
- Bit decision point: `edge_cnt`=P-1. At this point `sampled_bit` is valid, because the votes at P/2-2..P/2 complete by P/2+2.
- START, at the decision point: if `sampled_bit`=1, pulse `strt_glitch` and go to IDLE. Otherwise go to DATA.
- DATA, at the decision point: shift `sampled_bit` into the shift register LSB-first and XOR it into the running parity. After bit DATA_WIDTH, go to PARITY if `par_en`=1, else to STOP.
- PARITY, at the decision point: an error exists if `sampled_bit` ≠ (running XOR ^ `par_typ`). Store this as an internal `par_fail` flag. Go to STOP.
- STOP, at the decision point, always return to IDLE, and:
  - `stp_err`=1 if `sampled_bit`=0.
  - `par_err`=1 if `par_fail` is set.
  - If neither error: `data_valid`=1 and `p_data` is loaded from the shift register.
- `p_data` holds until the next accepted frame. Rejected frames never alter `p_data`.
- `data_samp_en`=1 in every non-IDLE state and 0 in IDLE. It must stay high through the whole frame, because `data_sampling` clears its votes when disabled.
- Line activity after the STOP decision is handled by IDLE on the next cycle. Back-to-back frames lose exactly one cycle of phase; this is tolerated.
- Input changes mid-frame (`prescale`, `par_en`, `par_typ`) have no effect until the next IDLE to START transition.

## Timing
- Reset values: state=IDLE; `edge_cnt`, `bit_cnt`, `p_data`, shift register, parity and `par_fail` all 0. `data_samp_en`, `data_valid`, `par_err`, `stp_err` and `strt_glitch` are 0.
- Reset asserted mid-frame: outputs return to reset values immediately. No pulse is emitted and the frame is lost.
- All outputs are registered.
- Pulse timing: take cycle 0 as the edge that sees `rx_in`=0 in IDLE. START occupies cycles 1..P. `data_valid`, `par_err` and `stp_err` are high on cycle 10P+1 without parity, or 11P+1 with parity, for exactly one cycle.
- `strt_glitch` is high on cycle P+1. `data_samp_en` falls on that same cycle.
- `par_err` and `stp_err` may both be asserted in the same cycle.
- A frame that starts IDLE on the cycle after STOP is accepted normally.

## Structure
- Shared package `uart_rx_pkg`: state enumeration, constants `PRESCALE_8`=8 and `PRESCALE_16`=16, and `DATA_WIDTH_DEF`=8.
- Sub-module `uart_rx_edge_bit_cnt`: edge and bit counters with wrap logic. Inputs are enable and latched prescale; outputs are `edge_cnt`, `bit_cnt` and a `bit_done` strobe at P-1.
- The FSM, deserializer and checks stay in `uart_rx_ctrl`.
- `uart_rx_ctrl` and `data_sampling` are instantiated side by side in the RX top level.

## Test plan
- P=8, no parity, frame 0xA5, stop=1: `p_data`=8'hA5 and `data_valid` pulses on cycle 81; no error flags.
- P=16, even parity, frame 0x3C, parity bit 1 (wrong): `par_err`=1 on cycle 177; `data_valid` stays 0 and `p_data` is unchanged.
- P=8, odd parity, frame 0x00, stop bit driven 0: `stp_err`=1 on cycle 89; `data_valid`=0.
- P=8, `rx_in` low for only 2 cycles, then high: `strt_glitch`=1 on cycle 9, the block returns to IDLE and `data_samp_en`=0.
- Two back-to-back P=8 frames, 0x55 then 0xF0, with no idle gap: both produce `data_valid` with the correct `p_data`.
- `rst` dropped at cycle 40 of a frame: all outputs are 0 immediately; the next frame is received correctly.
